float_mul_master: RTL and testbench
===================================

// Module: float_mul_master
// PURPOSE
//  Initiator side of the float_mul start/ready handshake: queues operand pairs, issues each job to one
//  float_mul, captures float_out on ready, returns products in order. Feeds float_mul inside invsqrt datapath.
// PARAMETERS
//  FIFO_DEPTH      4    operand-pair queue depth (power of two, >=2)
//  TIMEOUT_CYCLES  64   WAIT-state watchdog limit (used only with FLOAT_MUL_TIMEOUT_EN)
// PORTS
//  clk        in   1   single clock, all logic on posedge
//  rst        in   1   synchronous, active-high reset
//  in_valid   in   1   operand pair valid
//  in_ready   out  1   queue not full (accept when in_valid & in_ready)
//  in_a       in   32  IEEE-754 single operand A
//  in_b       in   32  IEEE-754 single operand B
//  out_valid  out  1   product valid (held until out_ready)
//  out_ready  in   1   consumer accepts product
//  out_p      out  32  product, bit-exact copy of float_out
//  mul_start  out  1   one-cycle start pulse to float_mul
//  mul_a      out  32  float_in_1; stable from start until capture
//  mul_b      out  32  float_in_2; stable from start until capture
//  mul_p      in   32  float_out from float_mul
//  mul_ready  in   1   ready from float_mul (level)
//  busy       out  1   high in ISSUE/WAIT or queue non-empty
//  timeout    out  1   sticky watchdog flag (constant 0 without FLOAT_MUL_TIMEOUT_EN)
// BEHAVIOUR
//  - Reset: all outputs 0 except in_ready=1; queue empty; state IDLE; ready_q=0; counters 0.
//  - Queue: FIFO_DEPTH entries, {a,b}; wr/rd pointers wrap mod FIFO_DEPTH, count is $clog2(FIFO_DEPTH)+1 bits.
//    in_ready = (count != FIFO_DEPTH). Simultaneous push+pop when full: disallowed (in_ready=0); when empty:
//    push lands, pop not possible same cycle (no bypass).
//  - FSM IDLE->ISSUE: count!=0 and output slot free (out_valid==0 | out_ready). Pop head into mul_a/mul_b.
//  - ISSUE (1 cycle): mul_start=1 -> WAIT. mul_start never high two consecutive cycles.
//  - WAIT: ready_q <= mul_ready each cycle. Capture on rising edge (mul_ready & ~ready_q): out_p<=mul_p,
//    out_valid<=1, -> IDLE. ready already high at ISSUE is ignored until it drops and rises again.
//  - Output: out_valid falls on out_valid&out_ready unless a new capture occurs same cycle (then stays 1,
//    out_p updated). Never overwrite an unaccepted product (IDLE gating guarantees it).
//  - Latency: empty queue, out_ready=1: in accept @T -> start @T+2 -> out_valid the cycle after ready rises.
//  - Order: strictly FIFO; exactly one job outstanding.
//  - rst mid-operation: job in flight and queue contents dropped; a late mul_ready rise is ignored (ready_q
//    cleared, state IDLE); float_mul must share rst.
// CONFIGURATION
//  FLOAT_MUL_TIMEOUT_EN defined: cycle counter in WAIT; reaching TIMEOUT_CYCLES sets timeout=1 (sticky until rst),
//    outputs out_p=32'h7FC00000 (qNaN) with out_valid=1, -> IDLE; subsequent jobs proceed.
//  Not defined: no counter, timeout tied 0, WAIT lasts until ready rises.
// TESTING
//  1 rst 2 cycles -> in_ready=1, out_valid=0, mul_start=0, busy=0, timeout=0.
//  2 push {3F800000,40000000} (1.0*2.0), model ready 3 cycles after start -> single start pulse, out_p=40000000.
//  3 push 6 pairs back-to-back, out_ready=1 -> in_ready drops after 4 queued, 6 products in push order
//    (incl. 3FC00000*3FC00000=40100000, 0*C0400000=80000000).
//  4 out_ready=0 after first product -> no second mul_start until out_ready=1; out_p held stable.
//  5 assert rst during WAIT, then ready pulse -> no out_valid, queue empty, busy=0.
//  6 FLOAT_MUL_TIMEOUT_EN, ready never rises -> after 64 WAIT cycles out_p=7FC00000, timeout=1 sticky.

Source files
------------

// File: rtl/float_mul_master.sv
// float_mul_master
//   Initiator side of the float_mul start/ready handshake. Operand pairs are
//   queued in a small FIFO, issued one at a time to a single float_mul, and
//   the products are returned in issue order through a valid/ready output.
//
// Parameters
//   FIFO_DEPTH      operand-pair queue depth (power of two, >= 2)
//   TIMEOUT_CYCLES  WAIT-state watchdog limit (only with FLOAT_MUL_TIMEOUT_EN)
//
// Build option
//   FLOAT_MUL_TIMEOUT_EN  when defined, a watchdog counts WAIT cycles and, on
//                         reaching TIMEOUT_CYCLES, returns qNaN and sets the
//                         sticky timeout flag. Undefined: timeout is tied 0.
//
// Ports
//   clk, rst                   clock, synchronous active-high reset
//   in_valid/in_ready/in_a/in_b   operand-pair input handshake
//   out_valid/out_ready/out_p     product output handshake
//   mul_start/mul_a/mul_b         job issue to float_mul
//   mul_p/mul_ready               result and ready level from float_mul
//   busy                          job in flight or queue non-empty
//   timeout                       sticky watchdog flag
module float_mul_master #(
    parameter int FIFO_DEPTH     = 4,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_a,
    input  logic [31:0] in_b,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_p,
    output logic        mul_start,
    output logic [31:0] mul_a,
    output logic [31:0] mul_b,
    input  logic [31:0] mul_p,
    input  logic        mul_ready,
    output logic        busy,
    output logic        timeout
);
    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;

    generate
        if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 || TIMEOUT_CYCLES < 1) begin : g_bad_cfg
            $error("float_mul_master: FIFO_DEPTH must be a power of two >= 2 and TIMEOUT_CYCLES >= 1");
        end
    endgenerate

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT} state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [31:0]      r_fifo_a [FIFO_DEPTH];
    logic [31:0]      r_fifo_b [FIFO_DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;
    logic             r_ready_q;
    logic             r_out_valid;
    logic [31:0]      r_out_p;
    logic [31:0]      r_mul_a;
    logic [31:0]      r_mul_b;
    logic             w_push;
    logic             w_pop;
    logic             w_capture;
    logic             w_expire;

    assign in_ready  = (r_count != CNT_W'(FIFO_DEPTH));
    assign w_push    = in_valid & in_ready;
    // Only pop when the output slot is free or being drained this cycle, so a
    // later capture can never overwrite an unaccepted product.
    assign w_pop     = (r_state == S_IDLE) & (r_count != '0) & (~r_out_valid | out_ready);
    // Capture on a rising edge of ready only; a level still high from the
    // previous job is not mistaken for completion.
    assign w_capture = (r_state == S_WAIT) & mul_ready & ~r_ready_q;

    assign out_valid = r_out_valid;
    assign out_p     = r_out_p;
    assign mul_a     = r_mul_a;
    assign mul_b     = r_mul_b;

`ifdef FLOAT_MUL_TIMEOUT_EN
    localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [TMO_W-1:0] r_wait_cnt;
    logic             r_timeout;

    // Counter reads k-1 in the k-th WAIT cycle, so expiry lands on WAIT cycle TIMEOUT_CYCLES.
    assign w_expire = (r_state == S_WAIT) & ~w_capture & (r_wait_cnt == TMO_W'(TIMEOUT_CYCLES - 1));
    assign timeout  = r_timeout;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wait_cnt <= '0;
            r_timeout  <= 1'b0;
        end else begin
            if (r_state != S_WAIT) begin
                r_wait_cnt <= '0;
            end else begin
                r_wait_cnt <= r_wait_cnt + TMO_W'(1);
            end
            if (w_expire) begin
                r_timeout <= 1'b1;
            end
        end
    end
`else
    assign w_expire = 1'b0;
    assign timeout  = 1'b0;
`endif

    // Queue storage: data only, no reset needed.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_fifo_a[r_wr_ptr] <= in_a;
            r_fifo_b[r_wr_ptr] <= in_b;
        end
    end

    // Queue control
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // FSM state register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // FSM next state
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (w_pop) w_state_nxt = S_ISSUE;
            S_ISSUE: w_state_nxt = S_WAIT;
            S_WAIT:  if (w_capture | w_expire) w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // FSM outputs
    always_comb begin
        mul_start = 1'b0;
        busy      = 1'b0;
        if (r_state == S_ISSUE) begin
            mul_start = 1'b1;
        end
        if (r_state != S_IDLE || r_count != '0) begin
            busy = 1'b1;
        end
    end

    // Operand issue and product capture
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ready_q   <= 1'b0;
            r_mul_a     <= '0;
            r_mul_b     <= '0;
            r_out_valid <= 1'b0;
            r_out_p     <= '0;
        end else begin
            r_ready_q <= mul_ready;
            if (w_pop) begin
                r_mul_a <= r_fifo_a[r_rd_ptr];
                r_mul_b <= r_fifo_b[r_rd_ptr];
            end
            if (w_capture) begin
                r_out_valid <= 1'b1;
                r_out_p     <= mul_p;
            end else if (w_expire) begin
                r_out_valid <= 1'b1;
                r_out_p     <= 32'h7FC0_0000;
            end else if (r_out_valid & out_ready) begin
                r_out_valid <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_float_mul_master.sv
module tb_float_mul_master;
    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_a;
    logic [31:0] in_b;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_p;
    logic        mul_start;
    logic [31:0] mul_a;
    logic [31:0] mul_b;
    logic [31:0] mul_p;
    logic        mul_ready;
    logic        busy;
    logic        timeout;

    always #5 clk = ~clk;

    // float_mul stand-in controls
    logic        manual;
    logic        man_ready;
    logic        mdl_ready;
    logic [31:0] mdl_p;
    int          fix_lat;
    logic        rand_lat;
    logic        hang;
    logic        expect_nan;

    assign mul_ready = manual ? man_ready : mdl_ready;
    assign mul_p     = mdl_p;

    int          total = 0;
    int          bad = 0;
    logic [31:0] expq[$];
    logic [31:0] out_log[$];
    int          n_start = 0;
    int          n_out = 0;
    int          n_pushed = 0;
    int          stall_at = -1;
    int          cyc = 0;
    int          acc_cyc = 0;
    int          start_cyc = 0;
    int          rise_cyc = 0;
    logic [31:0] last_p = '0;

    float_mul_master #(.FIFO_DEPTH(4), .TIMEOUT_CYCLES(64)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
        .out_valid(out_valid), .out_ready(out_ready), .out_p(out_p),
        .mul_start(mul_start), .mul_a(mul_a), .mul_b(mul_b),
        .mul_p(mul_p), .mul_ready(mul_ready),
        .busy(busy), .timeout(timeout)
    );

    // Single-precision product for normal/zero operands, truncating rounding.
    function automatic logic [31:0] fmul(input logic [31:0] a, input logic [31:0] b);
        logic        s;
        int          e;
        logic [47:0] m;
        s = a[31] ^ b[31];
        if (a[30:23] == 8'd0 || b[30:23] == 8'd0) return {s, 31'd0};
        m = {24'd0, 1'b1, a[22:0]} * {24'd0, 1'b1, b[22:0]};
        e = int'(a[30:23]) + int'(b[30:23]) - 127;
        if (m[47]) begin
            e = e + 1;
            return {s, e[7:0], m[46:24]};
        end
        return {s, e[7:0], m[45:23]};
    endfunction

    function automatic logic [31:0] rand_op();
        logic [7:0] e;
        e = ($urandom_range(0, 9) == 0) ? 8'd0 : 8'($urandom_range(100, 154));
        return {1'($urandom_range(0, 1)), e, 23'($urandom)};
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    // float_mul stand-in: drops ready on start, raises it with the product after the latency.
    initial begin
        int          mcnt;
        logic [31:0] mhold;
        mdl_ready = 1'b0;
        mdl_p     = '0;
        mcnt      = 0;
        mhold     = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                mcnt      = 0;
                mdl_ready = 1'b0;
            end else if (mul_start) begin
                mdl_ready = 1'b0;
                mhold     = fmul(mul_a, mul_b);
                mcnt      = rand_lat ? int'($urandom_range(1, 6)) : fix_lat;
            end else if (mcnt > 0) begin
                mcnt--;
                if (mcnt == 0 && !hang) begin
                    mdl_p     = mhold;
                    mdl_ready = 1'b1;
                end
            end
        end
    end

    // Compare process: scoreboard of accepted pairs against delivered products.
    task automatic monitor();
        logic        prev_start = 1'b0;
        logic        prev_ov = 1'b0;
        logic        prev_or = 1'b0;
        logic [31:0] prev_p = '0;
        logic        outstanding = 1'b0;
        forever begin
            @(negedge clk);
            cyc++;
            if (rst) begin
                expq.delete();
                outstanding = 1'b0;
                prev_start  = 1'b0;
                prev_ov     = 1'b0;
                prev_or     = 1'b0;
            end else begin
                if (!busy) chk("busy_vs_pending", expq.size(), out_valid ? 32'd1 : 32'd0);
                if (prev_ov && !prev_or) begin
                    chk("hold_valid", 32'(out_valid), 32'd1);
                    chk("hold_data", out_p, prev_p);
                end
                if (out_valid && !prev_ov) begin
                    outstanding = 1'b0;
                    rise_cyc    = cyc;
                end
                if (mul_start) begin
                    chk("start_gap", 32'(prev_start), 32'd0);
                    chk("one_outstanding", 32'(outstanding), 32'd0);
                    chk("start_slot_free", 32'(out_valid), 32'd0);
                    outstanding = 1'b1;
                    n_start++;
                    start_cyc = cyc;
                end
                if (out_valid && out_ready) begin
                    if (expq.size() == 0) begin
                        total++;
                        bad++;
                        $display("FAIL unexpected_out: got %h want none", out_p);
                    end else begin
                        chk("product", out_p, expq.pop_front());
                    end
                    out_log.push_back(out_p);
                    last_p = out_p;
                    n_out++;
                end
                if (in_valid && in_ready) begin
                    expq.push_back(expect_nan ? 32'h7FC0_0000 : fmul(in_a, in_b));
                    acc_cyc = cyc;
                end
                prev_start = mul_start;
                prev_ov    = out_valid;
                prev_or    = out_ready;
                prev_p     = out_p;
            end
        end
    endtask

    // Called at posedge+1; returns at posedge+1 after the pair is accepted.
    task automatic push(input logic [31:0] a, input logic [31:0] b);
        logic ok;
        ok       = 1'b0;
        in_valid = 1'b1;
        in_a     = a;
        in_b     = b;
        for (int k = 0; k < 300; k++) begin
            @(negedge clk);
            if (in_ready) begin
                ok = 1'b1;
                break;
            end
            if (stall_at < 0) stall_at = n_pushed;
        end
        if (!ok) begin
            total++;
            bad++;
            $display("FAIL push_wait: in_ready stuck at 0 want 1");
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        n_pushed++;
    endtask

    task automatic drain();
        logic ok;
        ok = 1'b0;
        for (int k = 0; k < 1000; k++) begin
            @(negedge clk);
            if (!busy && !out_valid) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            total++;
            bad++;
            $display("FAIL drain: busy=%0b out_valid=%0b want 0 0", busy, out_valid);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ov(input int limit);
        logic ok;
        ok = 1'b0;
        for (int k = 0; k < limit; k++) begin
            @(negedge clk);
            if (out_valid) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            total++;
            bad++;
            $display("FAIL wait_out_valid: got 0 want 1");
        end
    endtask

    initial begin
        int   base_s;
        int   base_o;
        int   seen;
        logic done;
        rst = 1'b1; in_valid = 1'b0; in_a = '0; in_b = '0; out_ready = 1'b1;
        manual = 1'b0; man_ready = 1'b0; fix_lat = 3; rand_lat = 1'b0;
        hang = 1'b0; expect_nan = 1'b0;
        fork
            monitor();
        join_none

        // 1: reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_mul_start", 32'(mul_start), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_timeout", 32'(timeout), 32'd0);
        chk("rst_out_p", out_p, 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // 2: single job 1.0*2.0, ready 3 cycles after start
        base_s = n_start; base_o = n_out;
        push(32'h3F80_0000, 32'h4000_0000);
        drain();
        chk("t2_starts", n_start - base_s, 32'd1);
        chk("t2_outs", n_out - base_o, 32'd1);
        chk("t2_product", last_p, 32'h4000_0000);
        chk("t2_acc_to_start", start_cyc - acc_cyc, 32'd2);
        chk("t2_start_to_out", rise_cyc - start_cyc, 32'd4);

        // 3: six back-to-back pushes against a slow multiplier
        fix_lat = 8; n_pushed = 0; stall_at = -1; base_o = n_out;
        push(32'h3FC0_0000, 32'h3FC0_0000);
        push(32'h0000_0000, 32'hC040_0000);
        push(32'h4040_0000, 32'h4080_0000);
        push(32'hBF80_0000, 32'h3F00_0000);
        push(32'h40A0_0000, 32'h40A0_0000);
        push(32'h3E80_0000, 32'h4200_0000);
        drain();
        chk("t3_stall_after", stall_at, 32'd5);
        chk("t3_outs", n_out - base_o, 32'd6);
        chk("t3_p0", out_log[base_o + 0], 32'h4010_0000);
        chk("t3_p1", out_log[base_o + 1], 32'h8000_0000);
        chk("t3_p2", out_log[base_o + 2], 32'h4140_0000);
        chk("t3_p3", out_log[base_o + 3], 32'hBF00_0000);

        // 4: back-pressure blocks the next issue
        fix_lat = 2; out_ready = 1'b0; base_s = n_start; base_o = n_out;
        push(32'h4000_0000, 32'h4040_0000);
        push(32'h3F80_0000, 32'hBF80_0000);
        wait_ov(100);
        repeat (10) @(negedge clk);
        chk("t4_no_second_start", n_start - base_s, 32'd1);
        chk("t4_held_valid", 32'(out_valid), 32'd1);
        chk("t4_held_p", out_p, 32'h40C0_0000);
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        drain();
        chk("t4_starts", n_start - base_s, 32'd2);
        chk("t4_last", last_p, 32'hBF80_0000);

        // 5: reset during WAIT, then a late ready edge
        fix_lat = 6; base_o = n_out;
        push(32'h4000_0000, 32'h4000_0000);
        push(32'h4040_0000, 32'h4040_0000);
        push(32'h4080_0000, 32'h4080_0000);
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        base_s = n_start;
        manual = 1'b1; man_ready = 1'b0;
        @(posedge clk);
        #1;
        man_ready = 1'b1;
        seen = 0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            if (out_valid) seen++;
        end
        chk("t5_no_out", seen, 32'd0);
        chk("t5_no_outs", n_out - base_o, 32'd0);
        chk("t5_busy", 32'(busy), 32'd0);
        chk("t5_in_ready", 32'(in_ready), 32'd1);
        chk("t5_no_restart", n_start - base_s, 32'd0);
        @(posedge clk);
        #1;
        man_ready = 1'b0; manual = 1'b0;

        // Randomized traffic: random operands, gaps, latency and back-pressure
        rand_lat = 1'b1; base_o = n_out; done = 1'b0;
        fork
            begin
                for (int i = 0; i < 40; i++) begin
                    int gap;
                    gap = int'($urandom_range(0, 2));
                    if (gap > 0) begin
                        repeat (gap) @(posedge clk);
                        #1;
                    end
                    push(rand_op(), rand_op());
                end
                done = 1'b1;
            end
            begin
                while (!done) begin
                    out_ready = ($urandom_range(0, 3) != 0);
                    @(posedge clk);
                    #1;
                end
                out_ready = 1'b1;
            end
        join
        drain();
        chk("rand_outs", n_out - base_o, 32'd40);
        rand_lat = 1'b0;

`ifdef FLOAT_MUL_TIMEOUT_EN
        // 6: watchdog returns qNaN after 64 WAIT cycles, flag sticks
        hang = 1'b1; expect_nan = 1'b1;
        push(32'h4000_0000, 32'h4000_0000);
        expect_nan = 1'b0;
        wait_ov(200);
        chk("t6_nan", out_p, 32'h7FC0_0000);
        chk("t6_timeout", 32'(timeout), 32'd1);
        chk("t6_wait_len", rise_cyc - start_cyc, 32'd65);
        drain();
        hang = 1'b0; fix_lat = 2;
        push(32'h4000_0000, 32'h4040_0000);
        drain();
        chk("t6_next_job", last_p, 32'h40C0_0000);
        chk("t6_sticky", 32'(timeout), 32'd1);
`else
        chk("timeout_tied", 32'(timeout), 32'd0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
